// File: rtl/wb_select_pipe_pkg.sv
// Shared encodings for the write-back stage: load types and default source indices.
// The control unit imports the same package so both sides agree on the encodings.
package wb_select_pipe_pkg;

    typedef enum logic [2:0] {
        LD_WORD   = 3'd0,
        LD_BYTE_S = 3'd1,
        LD_BYTE_U = 3'd2,
        LD_HALF_S = 3'd3,
        LD_HALF_U = 3'd4
    } ld_type_e;

    localparam int unsigned SRC_ALU  = 0;
    localparam int unsigned SRC_MEM  = 1;
    localparam int unsigned SRC_LINK = 2;

endpackage

// File: rtl/wb_select_pipe_load_extract.sv
// Sub-word load extraction: picks a little-endian byte/half lane and sign/zero extends it.
// Purely combinational.
module wb_select_pipe_load_extract
    import wb_select_pipe_pkg::*;
#(
    parameter int unsigned NB_DATA = 32
) (
    input  logic [NB_DATA-1:0] data_i,
    input  logic [2:0]         load_type_i,
    input  logic [1:0]         addr_lsb_i,
    output logic [NB_DATA-1:0] data_o
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Half lane only looks at addr bit 1; bit 0 is ignored on purpose.
    assign lane_b = data_i[{addr_lsb_i, 3'b000} +: 8];
    assign lane_h = data_i[{addr_lsb_i[1], 4'b0000} +: 16];

    always_comb begin
        data_o = data_i;
        case (load_type_i)
            LD_BYTE_S: data_o = {{(NB_DATA-8){lane_b[7]}}, lane_b};
            LD_BYTE_U: data_o = {{(NB_DATA-8){1'b0}}, lane_b};
            LD_HALF_S: data_o = {{(NB_DATA-16){lane_h[15]}}, lane_h};
            LD_HALF_U: data_o = {{(NB_DATA-16){1'b0}}, lane_h};
            default:   data_o = data_i;
        endcase
    end

endmodule

// File: rtl/wb_select_pipe.sv
// Write-back select stage: source mux, load extraction, stallable/flushable output
// register and a counter of retired register-file writes.
module wb_select_pipe
    import wb_select_pipe_pkg::*;
#(
    parameter int unsigned NB_DATA = 32,
    parameter int unsigned NB_REG  = 5,
    parameter int unsigned N_SRC   = 4,
    parameter int unsigned NB_SEL  = 2,
    parameter int unsigned MEM_SRC = SRC_MEM,
    parameter int unsigned NB_CNT  = 32
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     valid_i,
    input  logic                     stall_i,
    input  logic                     flush_i,
    input  logic [N_SRC*NB_DATA-1:0] src_i,
    input  logic [NB_SEL-1:0]        sel_i,
    input  logic [2:0]               load_type_i,
    input  logic [1:0]               addr_lsb_i,
    input  logic [NB_REG-1:0]        reg_dst_i,
    input  logic                     reg_write_i,
    output logic [NB_DATA-1:0]       data_o,
    output logic [NB_REG-1:0]        reg_dst_o,
    output logic                     reg_write_o,
    output logic                     valid_o,
    output logic [NB_CNT-1:0]        wb_count_o
);

    logic [NB_DATA-1:0] src_sel;
    logic [NB_DATA-1:0] src_ext;
    logic [NB_DATA-1:0] wb_data;
    logic               is_mem;
    logic               write_d;

    // Out-of-range selects fall back to source 0.
    always_comb begin
        src_sel = src_i[0 +: NB_DATA];
        for (int k = 1; k < int'(N_SRC); k++) begin
            if (sel_i == NB_SEL'(k)) begin
                src_sel = src_i[k*NB_DATA +: NB_DATA];
            end
        end
    end

    wb_select_pipe_load_extract #(
        .NB_DATA(NB_DATA)
    ) u_load_extract (
        .data_i     (src_sel),
        .load_type_i(load_type_i),
        .addr_lsb_i (addr_lsb_i),
        .data_o     (src_ext)
    );

    assign is_mem  = (sel_i == NB_SEL'(MEM_SRC));
    assign wb_data = is_mem ? src_ext : src_sel;
    assign write_d = valid_i & reg_write_i & (reg_dst_i != '0);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            data_o      <= '0;
            reg_dst_o   <= '0;
            reg_write_o <= 1'b0;
            valid_o     <= 1'b0;
            wb_count_o  <= '0;
        end else if (flush_i) begin
            data_o      <= wb_data;
            reg_dst_o   <= reg_dst_i;
            reg_write_o <= 1'b0;
            valid_o     <= 1'b0;
        end else if (!stall_i) begin
            data_o      <= wb_data;
            reg_dst_o   <= reg_dst_i;
            reg_write_o <= write_d;
            valid_o     <= valid_i;
            wb_count_o  <= wb_count_o + NB_CNT'(write_d);
        end
    end

endmodule
